// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: game-time sequencer driving the BCD mm:ss counter's clear/tick
// enables from game events, and keeping the best winning time across games.
module game_timer_ctrl #(
    parameter int          TICK_DIV = 100_000_000,
    parameter logic [15:0] MAX_TIME = 16'h5959
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_start_i,
    input  logic        pause_tog_i,
    input  logic        game_win_i,
    input  logic        game_lose_i,
    input  logic [15:0] time_i,
    output logic        cnt_clr_o,
    output logic        cnt_tick_o,
    output logic [1:0]  state_o,
    output logic        sat_o,
    output logic [15:0] best_time_o,
    output logic        best_valid_o,
    output logic        new_record_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    localparam logic [26:0] TOP = 27'(TICK_DIV - 1);

    state_t      state, state_next;
    logic [26:0] presc, presc_next;
    logic        active, win, lose, tog, wrap, record;

    always_comb begin
        active     = (state == RUN) || (state == PAUSE);
        win        = active && game_win_i && !game_start_i;
        lose       = active && game_lose_i && !game_win_i && !game_start_i;
        tog        = active && pause_tog_i && !game_lose_i && !game_win_i && !game_start_i;
        wrap       = (state == RUN) && (presc == TOP);
        record     = win && (!best_valid_o || time_i < best_time_o);
        state_next = state;
        if (game_start_i)
            state_next = RUN;
        else if (win || lose)
            state_next = DONE;
        else if (tog)
            state_next = (state == RUN) ? PAUSE : RUN;
        // PAUSE holds the partial second; only RUN cycles advance the prescaler
        presc_next = game_start_i ? 27'd0 :
                     (state == RUN) ? (wrap ? 27'd0 : presc + 27'd1) :
                     (state == PAUSE) ? presc : 27'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            presc        <= '0;
            cnt_clr_o    <= 1'b0;
            cnt_tick_o   <= 1'b0;
            best_time_o  <= '0;
            best_valid_o <= 1'b0;
            new_record_o <= 1'b0;
        end else begin
            state        <= state_next;
            presc        <= presc_next;
            cnt_clr_o    <= game_start_i;
            cnt_tick_o   <= wrap && !game_start_i && (time_i != MAX_TIME);
            new_record_o <= record;
            if (record) begin
                best_time_o  <= time_i;
                best_valid_o <= 1'b1;
            end
        end
    end

    assign state_o = state;
    assign sat_o   = (state == RUN) && (time_i == MAX_TIME);
endmodule
